// File: rtl/lock_controller.sv
// Digital lock sequencing FSM: code entry, compare, timed unlock/lockout and code programming.
// Optional `LOCK_ALARM_EN adds an alarm output (high in lockout, 1-cycle pulse on each wrong code).
module lock_controller #(
    parameter int                          CODE_LEN     = 4,
    parameter int                          DIGIT_W      = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                          MAX_FAIL     = 3,
    parameter logic [27:0]                 UNLOCK_CYC   = 28'd100_000_000,
    parameter logic [27:0]                 LOCKOUT_CYC  = 28'd200_000_000
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_push,
    input  logic               clear_push,
    input  logic               prog_hold,
    output logic               unlocked,
    output logic               locked_out,
    output logic               prog_mode,
    output logic [3:0]         entry_cnt,
    output logic [2:0]         fail_cnt
`ifdef LOCK_ALARM_EN
    ,
    output logic               alarm
`endif
);

    localparam int CW = CODE_LEN * DIGIT_W;

    localparam logic [2:0] S_LOCKED  = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
    localparam logic [2:0] S_PROG    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] entry_q, entry_d;
    logic [CW-1:0] code_q, code_d;
    logic [3:0]    cnt_d;
    logic [2:0]    fail_d;
    logic [27:0]   timer_q, timer_d;
    logic          mismatch;

    logic          digit_ok;
    logic          last_digit;
    logic [CW-1:0] entry_shift;

    assign digit_ok    = digit_push && (digit_in <= DIGIT_W'(9));
    assign last_digit  = (entry_cnt == 4'(CODE_LEN - 1));
    assign entry_shift = {entry_q[CW-DIGIT_W-1:0], digit_in};

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        code_d   = code_q;
        cnt_d    = entry_cnt;
        fail_d   = fail_cnt;
        timer_d  = timer_q;
        mismatch = 1'b0;

        case (state_q)
            S_LOCKED, S_PROG: begin
                if (state_q == S_PROG && prog_hold) begin
                    state_d = S_LOCKED;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (clear_push) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (digit_ok) begin
                    entry_d = entry_shift;
                    cnt_d   = entry_cnt + 4'd1;
                    if (last_digit) begin
                        if (state_q == S_PROG) begin
                            code_d  = entry_shift;
                            entry_d = '0;
                            cnt_d   = '0;
                            state_d = S_LOCKED;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end

            S_CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (entry_q == code_q) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                    timer_d = UNLOCK_CYC - 28'd1;
                end else begin
                    mismatch = 1'b1;
                    if (fail_cnt + 3'd1 == 3'(MAX_FAIL)) begin
                        state_d = S_LOCKOUT;
                        fail_d  = '0;
                        timer_d = LOCKOUT_CYC - 28'd1;
                    end else begin
                        state_d = S_LOCKED;
                        fail_d  = fail_cnt + 3'd1;
                    end
                end
            end

            // Programming request wins over timer expiry on the same cycle.
            S_OPEN: begin
                if (prog_hold) begin
                    state_d = S_PROG;
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = S_LOCKED;
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end

            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_LOCKED;
                    entry_d = '0;
                    cnt_d   = '0;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end

            default: state_d = S_LOCKED;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= S_LOCKED;
            entry_q    <= '0;
            // NOTE: the stored code is a plain register, so reset reloads it like any other state.
            code_q     <= DEFAULT_CODE;
            entry_cnt  <= '0;
            fail_cnt   <= '0;
            timer_q    <= '0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            prog_mode  <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            code_q     <= code_d;
            entry_cnt  <= cnt_d;
            fail_cnt   <= fail_d;
            timer_q    <= timer_d;
            unlocked   <= (state_d == S_OPEN);
            locked_out <= (state_d == S_LOCKOUT);
            prog_mode  <= (state_d == S_PROG);
        end
    end

`ifdef LOCK_ALARM_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else begin
            alarm <= (state_d == S_LOCKOUT) || mismatch;
        end
    end
`endif

endmodule

// File: tb/tb_lock_controller.sv
// Self-checking bench for lock_controller: fixed vector table, directed corner sequences,
// and randomized traffic compared every cycle against a digit-queue reference model.
module tb_lock_controller;

    localparam int CODE_LEN = 4;
    localparam int MAX_FAIL = 3;
    localparam int UNLOCK   = 10;
    localparam int LOCKOUT  = 20;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_in = '0;
    logic       digit_push = 1'b0;
    logic       clear_push = 1'b0;
    logic       prog_hold = 1'b0;
    logic       unlocked, locked_out, prog_mode;
    logic [3:0] entry_cnt;
    logic [2:0] fail_cnt;
`ifdef LOCK_ALARM_EN
    logic       alarm;
`endif

    lock_controller #(
        .CODE_LEN    (CODE_LEN),
        .DIGIT_W     (4),
        .DEFAULT_CODE(16'h1234),
        .MAX_FAIL    (MAX_FAIL),
        .UNLOCK_CYC  (28'd10),
        .LOCKOUT_CYC (28'd20)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .digit_in  (digit_in),
        .digit_push(digit_push),
        .clear_push(clear_push),
        .prog_hold (prog_hold),
        .unlocked  (unlocked),
        .locked_out(locked_out),
        .prog_mode (prog_mode),
        .entry_cnt (entry_cnt),
        .fail_cnt  (fail_cnt)
`ifdef LOCK_ALARM_EN
        ,
        .alarm     (alarm)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the entry is a queue of digits, the code an array of digits,
    // and open/lockout time is a count of cycles still to be spent in that mode.
    typedef enum {M_LOCKED, M_CHECK, M_OPEN, M_LOCKOUT, M_PROG} mode_t;
    mode_t m_mode;
    int    digits[$];
    int    code_m[CODE_LEN];
    int    fails;
    int    remaining;
    bit    alarm_m;

    function automatic void model_step(bit dp, int d, bit cp, bit ph, bit rst);
        bit ok;
        if (rst) begin
            m_mode = M_LOCKED;
            digits.delete();
            code_m = '{1, 2, 3, 4};
            fails = 0;
            remaining = 0;
            alarm_m = 0;
            return;
        end
        alarm_m = 0;
        case (m_mode)
            M_CHECK: begin
                ok = 1;
                for (int i = 0; i < CODE_LEN; i++) if (digits[i] != code_m[i]) ok = 0;
                digits.delete();
                if (ok) begin
                    m_mode = M_OPEN;
                    remaining = UNLOCK;
                    fails = 0;
                end else begin
                    alarm_m = 1;
                    if (fails + 1 == MAX_FAIL) begin
                        m_mode = M_LOCKOUT;
                        remaining = LOCKOUT;
                        fails = 0;
                    end else begin
                        fails++;
                        m_mode = M_LOCKED;
                    end
                end
            end
            M_OPEN: begin
                if (ph) begin
                    m_mode = M_PROG;
                    digits.delete();
                end else begin
                    remaining--;
                    if (remaining == 0) m_mode = M_LOCKED;
                end
            end
            M_LOCKOUT: begin
                remaining--;
                if (remaining == 0) begin
                    m_mode = M_LOCKED;
                    digits.delete();
                    fails = 0;
                end else begin
                    alarm_m = 1;
                end
            end
            default: begin
                if (m_mode == M_PROG && ph) begin
                    m_mode = M_LOCKED;
                    digits.delete();
                end else if (cp) begin
                    digits.delete();
                end else if (dp && d <= 9) begin
                    digits.push_back(d);
                    if (digits.size() == CODE_LEN) begin
                        if (m_mode == M_PROG) begin
                            for (int i = 0; i < CODE_LEN; i++) code_m[i] = digits[i];
                            digits.delete();
                            m_mode = M_LOCKED;
                        end else begin
                            m_mode = M_CHECK;
                        end
                    end
                end
            end
        endcase
    endfunction

    task automatic compare_model();
        check("m_unlocked", 32'(unlocked), 32'(m_mode == M_OPEN));
        check("m_locked_out", 32'(locked_out), 32'(m_mode == M_LOCKOUT));
        check("m_prog_mode", 32'(prog_mode), 32'(m_mode == M_PROG));
        check("m_entry_cnt", 32'(entry_cnt), 32'(digits.size()));
        check("m_fail_cnt", 32'(fail_cnt), 32'(fails));
`ifdef LOCK_ALARM_EN
        check("m_alarm", 32'(alarm), 32'(alarm_m));
`endif
    endtask

    // One clock: drive on the falling edge, step the model at the rising edge, compare 1 ns later.
    task automatic cycle(input bit dp, input int d, input bit cp, input bit ph, input bit rst);
        @(negedge clk_in);
        digit_push = dp;
        digit_in   = d[3:0];
        clear_push = cp;
        prog_hold  = ph;
        rst_n      = !rst;
        @(posedge clk_in);
        #1;
        model_step(dp, d & 15, cp, ph, rst);
        compare_model();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int e);
        cycle(1, a, 0, 0, 0);
        cycle(1, b, 0, 0, 0);
        cycle(1, c, 0, 0, 0);
        cycle(1, e, 0, 0, 0);
    endtask

    typedef struct {
        bit dp; int d; bit cp; bit ph;
        bit unl; int cnt; int fail; bit lo; bit pg;
    } vec_t;
    vec_t tbl[16];

    initial begin
        int hi;
        int lo;
        // dp  d  cp ph | unl cnt fail lo pg
        tbl[0]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 0, 0, 2, 0, 0, 0};
        tbl[2]  = '{1, 7, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{1, 11, 0, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 2, 0, 0, 0, 2, 0, 0, 0};
        tbl[6]  = '{1, 3, 0, 0, 0, 3, 0, 0, 0};
        tbl[7]  = '{1, 5, 0, 0, 0, 4, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
        tbl[10] = '{1, 2, 0, 0, 0, 2, 1, 0, 0};
        tbl[11] = '{1, 3, 0, 0, 0, 3, 1, 0, 0};
        tbl[12] = '{1, 4, 0, 0, 0, 4, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{1, 9, 1, 0, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("rst_unlocked", 32'(unlocked), 0);
        check("rst_entry_cnt", 32'(entry_cnt), 0);
        check("rst_fail_cnt", 32'(fail_cnt), 0);

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].dp, tbl[i].d, tbl[i].cp, tbl[i].ph, 0);
            check($sformatf("tbl%0d_unlocked", i), 32'(unlocked), 32'(tbl[i].unl));
            check($sformatf("tbl%0d_entry_cnt", i), 32'(entry_cnt), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_fail_cnt", i), 32'(fail_cnt), 32'(tbl[i].fail));
            check($sformatf("tbl%0d_locked_out", i), 32'(locked_out), 32'(tbl[i].lo));
            check($sformatf("tbl%0d_prog_mode", i), 32'(prog_mode), 32'(tbl[i].pg));
        end

        // Rows 13..15 already saw three open cycles.
        hi = 3;
        for (int k = 0; k < 30 && unlocked; k++) begin
            idle();
            if (unlocked) hi++;
        end
        check("open_length", hi, UNLOCK);

        // Three wrong codes in a row lead to lockout.
        enter_code(1, 2, 3, 5);
        idle();
        check("wrong1_fail_cnt", 32'(fail_cnt), 1);
`ifdef LOCK_ALARM_EN
        check("wrong1_alarm_pulse", 32'(alarm), 1);
        idle();
        check("wrong1_alarm_drop", 32'(alarm), 0);
`endif
        enter_code(1, 2, 3, 5);
        idle();
        check("wrong2_fail_cnt", 32'(fail_cnt), 2);
        check("wrong2_unlocked", 32'(unlocked), 0);
        enter_code(1, 2, 3, 5);
        idle();
        lo = 0;
        for (int k = 0; k < 40 && locked_out; k++) begin
            lo++;
`ifdef LOCK_ALARM_EN
            check("lockout_alarm", 32'(alarm), 1);
`endif
            cycle(1, 1, 0, 0, 0);
        end
        check("lockout_length", lo, LOCKOUT);
        check("lockout_exit_fail", 32'(fail_cnt), 0);
        check("lockout_exit_entry", 32'(entry_cnt), 0);

        // Programming a new code.
        enter_code(1, 2, 3, 4);
        idle();
        check("prog_pre_open", 32'(unlocked), 1);
        cycle(0, 0, 0, 1, 0);
        check("prog_enter", 32'(prog_mode), 1);
        enter_code(9, 8, 7, 6);
        check("prog_done", 32'(prog_mode), 0);
        check("prog_done_cnt", 32'(entry_cnt), 0);
        enter_code(1, 2, 3, 4);
        idle();
        check("old_code_rejected", 32'(unlocked), 0);
        enter_code(9, 8, 7, 6);
        idle();
        check("new_code_opens", 32'(unlocked), 1);

        // Abort programming part-way; code must stay 9876.
        cycle(0, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check("abort_prog_mode", 32'(prog_mode), 0);
        check("abort_entry_cnt", 32'(entry_cnt), 0);
        enter_code(9, 8, 7, 6);
        idle();
        check("abort_code_kept", 32'(unlocked), 1);

        // Reset mid-OPEN restores the default code.
        idle();
        cycle(0, 0, 0, 0, 1);
        check("midrst_unlocked", 32'(unlocked), 0);
        check("midrst_fail_cnt", 32'(fail_cnt), 0);
        enter_code(1, 2, 3, 4);
        idle();
        check("midrst_default_code", 32'(unlocked), 1);

        // Random traffic, biased toward the current code so every mode gets exercised.
        for (int k = 0; k < 4000; k++) begin
            bit dp, cp, ph, rst;
            int d;
            dp  = ($urandom_range(0, 1) == 1);
            cp  = ($urandom_range(0, 19) == 0);
            ph  = ($urandom_range(0, 14) == 0);
            rst = ($urandom_range(0, 499) == 0);
            if (digits.size() < CODE_LEN && $urandom_range(0, 1) == 1)
                d = code_m[digits.size()];
            else
                d = $urandom_range(0, 15);
            cycle(dp, d, cp, ph, rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
